// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, ALU operation encodings and the
// ID/EX control bundle produced by the decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_SUMA  = 2'b00;
    localparam logic [1:0] ALU_RESTA = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic       destino_reg;
        logic       salto;
        logic       branch;
        logic       mem_leer;
        logic       mem_a_reg;
        logic       mem_escribir;
        logic       alu_fuente;
        logic       reg_escribir;
        logic [1:0] alu_operacion;
        logic       ilegal;
    } control_t;

    function automatic control_t decodificar(input logic [5:0] op);
        control_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.destino_reg   = 1'b1;
                c.reg_escribir  = 1'b1;
                c.alu_operacion = ALU_FUNCT;
            end
            OP_LW: begin
                c.alu_fuente    = 1'b1;
                c.mem_leer      = 1'b1;
                c.mem_a_reg     = 1'b1;
                c.reg_escribir  = 1'b1;
                c.alu_operacion = ALU_SUMA;
            end
            OP_SW: begin
                c.alu_fuente    = 1'b1;
                c.mem_escribir  = 1'b1;
                c.alu_operacion = ALU_SUMA;
            end
            OP_BEQ: begin
                c.branch        = 1'b1;
                c.alu_operacion = ALU_RESTA;
            end
            OP_ADDI: begin
                c.alu_fuente    = 1'b1;
                c.reg_escribir  = 1'b1;
                c.alu_operacion = ALU_SUMA;
            end
            OP_J:    c.salto  = 1'b1;
            default: c.ilegal = 1'b1;
        endcase
        return c;
    endfunction

    // Instructions whose rt field is a source operand (and so can hit a load-use hazard).
    function automatic logic usa_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/banco_registros_param.sv
// Two-read, one-write register file; r0 hardwired to zero, write-first bypass
// on both read ports, synchronous clear.
module banco_registros_param #(
    parameter int ANCHO   = 32,
    parameter int NUM_REG = 32,
    parameter int AW      = $clog2(NUM_REG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [AW-1:0]    wa_i,
    input  logic [ANCHO-1:0] wd_i,
    input  logic [AW-1:0]    ra1_i,
    input  logic [AW-1:0]    ra2_i,
    output logic [ANCHO-1:0] rd1_o,
    output logic [ANCHO-1:0] rd2_o
);

    logic [ANCHO-1:0] regs_q [NUM_REG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REG; i++) regs_q[i] <= '0;
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    function automatic logic [ANCHO-1:0] leer(input logic [AW-1:0] ra);
        if (ra == '0)                return '0;
        else if (we_i && wa_i == ra) return wd_i;
        else                         return regs_q[ra];
    endfunction

    assign rd1_o = leer(ra1_i);
    assign rd2_o = leer(ra2_i);

endmodule

// File: rtl/decodificador_segmentado.sv
// ID stage of a 5-stage MIPS pipeline: decode, register read, load-use stall
// detection and the ID/EX pipeline register.
module decodificador_segmentado
    import mips_pkg::*;
#(
    parameter int ANCHO   = 32,
    parameter int NUM_REG = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instruccion,
    input  logic [ANCHO-1:0] pc_plus4_in,
    input  logic             reg_escribir_wb,
    input  logic [4:0]       rd_wb,
    input  logic [ANCHO-1:0] dato_escribir,
    input  logic             vaciar,
    output logic             detener,
    output logic             destino_reg,
    output logic             salto,
    output logic             branch,
    output logic             mem_leer,
    output logic             mem_a_reg,
    output logic             mem_escribir,
    output logic             alu_fuente,
    output logic             reg_escribir,
    output logic [1:0]       alu_operacion,
    output logic [ANCHO-1:0] dr1,
    output logic [ANCHO-1:0] dr2,
    output logic [ANCHO-1:0] ext,
    output logic [ANCHO-1:0] pc_plus4_ID,
    output logic [ANCHO-1:0] jump_address,
    output logic [5:0]       funct,
    output logic [4:0]       rt_out,
    output logic [4:0]       rd_out,
    output logic             valido,
    output logic             ilegal
);

    localparam int AW = $clog2(NUM_REG);

    logic [5:0] opcode;
    logic [4:0] rs, rt, rd;
    assign opcode = instruccion[31:26];
    assign rs     = instruccion[25:21];
    assign rt     = instruccion[20:16];
    assign rd     = instruccion[15:11];

    logic [ANCHO-1:0] lect1, lect2;

    banco_registros_param #(.ANCHO(ANCHO), .NUM_REG(NUM_REG), .AW(AW)) u_banco (
        .clk   (clk),
        .reset (reset),
        .we_i  (reg_escribir_wb),
        .wa_i  (rd_wb[AW-1:0]),
        .wd_i  (dato_escribir),
        .ra1_i (rs[AW-1:0]),
        .ra2_i (rt[AW-1:0]),
        .rd1_o (lect1),
        .rd2_o (lect2)
    );

    control_t         ctrl_d, ctrl_q;
    logic [ANCHO-1:0] dr1_d, dr1_q, dr2_d, dr2_q, ext_d, ext_q;
    logic [ANCHO-1:0] pc_d, pc_q, ja_d, ja_q;
    logic [5:0]       funct_d, funct_q;
    logic [4:0]       rt_d, rt_q, rd_d, rd_q;
    logic             valido_d, valido_q;
    logic             riesgo;

    // Load in EX whose destination is a source of the instruction now in ID.
    assign riesgo = ctrl_q.mem_leer && (rt_q != 5'd0) &&
                    ((rt_q == rs) || (usa_rt(opcode) && (rt_q == rt)));
    assign detener = !reset && !vaciar && riesgo;

    always_comb begin
        ctrl_d   = '0;
        dr1_d    = '0;
        dr2_d    = '0;
        ext_d    = '0;
        pc_d     = '0;
        ja_d     = '0;
        funct_d  = '0;
        rt_d     = '0;
        rd_d     = '0;
        valido_d = 1'b0;
        if (!vaciar && !riesgo) begin
            ctrl_d   = decodificar(opcode);
            dr1_d    = lect1;
            dr2_d    = lect2;
            ext_d    = {{(ANCHO-16){instruccion[15]}}, instruccion[15:0]};
            pc_d     = pc_plus4_in;
            ja_d     = {pc_plus4_in[ANCHO-1:28], instruccion[25:0], 2'b00};
            funct_d  = instruccion[5:0];
            rt_d     = rt;
            rd_d     = rd;
            valido_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= '0;
            dr1_q    <= '0;
            dr2_q    <= '0;
            ext_q    <= '0;
            pc_q     <= '0;
            ja_q     <= '0;
            funct_q  <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            valido_q <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            dr1_q    <= dr1_d;
            dr2_q    <= dr2_d;
            ext_q    <= ext_d;
            pc_q     <= pc_d;
            ja_q     <= ja_d;
            funct_q  <= funct_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            valido_q <= valido_d;
        end
    end

    assign destino_reg   = ctrl_q.destino_reg;
    assign salto         = ctrl_q.salto;
    assign branch        = ctrl_q.branch;
    assign mem_leer      = ctrl_q.mem_leer;
    assign mem_a_reg     = ctrl_q.mem_a_reg;
    assign mem_escribir  = ctrl_q.mem_escribir;
    assign alu_fuente    = ctrl_q.alu_fuente;
    assign reg_escribir  = ctrl_q.reg_escribir;
    assign alu_operacion = ctrl_q.alu_operacion;
    assign ilegal        = ctrl_q.ilegal;
    assign dr1           = dr1_q;
    assign dr2           = dr2_q;
    assign ext           = ext_q;
    assign pc_plus4_ID   = pc_q;
    assign jump_address  = ja_q;
    assign funct         = funct_q;
    assign rt_out        = rt_q;
    assign rd_out        = rd_q;
    assign valido        = valido_q;

endmodule

// File: doc/decodificador_segmentado.md
DECODIFICADOR_SEGMENTADO -- requirements
Module: decodificador_segmentado

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ANCHO, 32, data width of registers, PC and immediates
- NUM_REG, 32, register count; address width is clog2(NUM_REG), max 5 bits.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- instruccion  in  32  IF/ID instruction word
- pc_plus4_in  in  ANCHO  IF/ID PC+4
- reg_escribir_wb  in  1  WB write enable
- rd_wb  in  5  WB destination register
- dato_escribir  in  ANCHO  WB write data
- vaciar  in  1  flush from EX (branch/jump taken)
- detener  out  1  combinational stall to PC and IF/ID
- Registered ID/EX outputs: destino_reg, salto, branch, mem_leer, mem_a_reg, mem_escribir, alu_fuente, reg_escribir (1 each); alu_operacion (2); dr1, dr2, ext, pc_plus4_ID, jump_address (ANCHO); funct (6); rt_out, rd_out (5); valido (1); ilegal (1).
REQ-003 One clock; reset SHALL be synchronous and active-high.

Function
REQ-004 Opcode decode SHALL be: 000000 R-type (destino_reg=1, reg_escribir=1, alu_operacion=10); 100011 lw (alu_fuente, mem_leer, mem_a_reg, reg_escribir, op 00); 101011 sw (alu_fuente, mem_escribir, op 00); 000100 beq (branch, op 01); 001000 addi (alu_fuente, reg_escribir, op 00); 000010 j (salto).
REQ-005 Any other opcode SHALL produce all-zero control and ilegal=1 in ID/EX.
REQ-006 ext SHALL be instruccion[15:0] sign-extended to ANCHO.
REQ-007 jump_address SHALL be {pc_plus4_in[ANCHO-1:28], instruccion[25:0], 2'b00}.
REQ-008 Register 0 SHALL read as 0 and ignore writes.
REQ-009 Writes SHALL occur on the rising clk edge when reg_escribir_wb=1 and rd_wb!=0.
REQ-010 The same-cycle read of a register being written SHALL return dato_escribir (write-first bypass).
REQ-011 Load-use hazard: detener SHALL be 1 when registered mem_leer=1 and registered rt_out!=0 and rt_out equals instruccion[25:21], or equals instruccion[20:16] for R-type, sw or beq.
REQ-012 On a hazard cycle, ID/EX SHALL load a bubble: all control 0, valido=0, data fields don't-care, held at 0.
REQ-013 vaciar=1 SHALL load a bubble and force detener=0 in that cycle.
REQ-014 Priority SHALL be reset > vaciar > hazard bubble > normal load.
REQ-015 Normal load SHALL set valido=1 and register all decoded fields; latency instruccion->ID/EX is 1 cycle.
REQ-016 After a stall, the held instruction SHALL be loaded on the next cycle, as the bubble cleared mem_leer.

Reset
REQ-017 reset=1 at a clock edge SHALL clear all ID/EX outputs (incl. valido, ilegal) and all registers to 0.
REQ-018 detener SHALL be 0 while reset=1 and in the first cycle after reset.
REQ-019 Reset mid-stall SHALL abandon the stall; no state survives.

Structure
REQ-020 Opcode constants and alu_operacion encodings (00/01/10) SHALL live in the shared package mips_pkg.
REQ-021 The register file SHALL be a sub-module banco_registros_param (ANCHO, NUM_REG), with a synchronous-reset clear and bypass.

Verification
REQ-022 Bench SHALL cover:
- Write r5=0x0000_00AA, then decode add r3,r5,r0 -> dr1=0xAA, valido=1, alu_operacion=10, destino_reg=1.
- WB writes r7=0x1234 in the same cycle as decode of rs=r7 -> dr1=0x1234 (bypass).
- lw r4,0(r1), then add r2,r4,r4 -> detener=1 for 1 cycle, bubble (valido=0), add in ID/EX next cycle.
- vaciar=1 during the load-use case -> detener=0, bubble loaded.
- Opcode 111111 -> ilegal=1, all control 0; addi imm 0xFFFE -> ext=0xFFFF_FFFE.
- reset asserted mid-stream after writing r9 -> all outputs 0, r9 reads 0.
